mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between two requesters of the 5-stage pipeline: instruction fetch (IF port) and load/store (ME port).
- Grants one access at a time, sequences the memory handshake and returns read data with a one-cycle ack.
- Drives per-stage stall flags into the pipeline hazard/stall logic.
- Sits between the IF/ME stages and the memory model; the memory runs on the CPU clock.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between IF fetch and ME load/store.
// ME wins ties; one access in flight at a time; memory strobe and acks are registered.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clock,
    input  logic          reset_0,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          stall_if,
    output logic          stall_me,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    // MEM_LAT is legal in 1..15, so a 4-bit down-counter covers it.
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t        state, state_n;
    owner_t        owner, owner_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          cancel, cancel_n;
    logic          mem_en_n, mem_we_n, i_ack_n, d_ack_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n, i_rdata_n, d_rdata_n;
    logic          flush_hit;

    // A flush only cancels an access that IF currently owns.
    assign flush_hit = (owner == OWN_I) && i_flush && ((state == ISSUE) || (state == WAIT));

    assign stall_if = i_req & ~i_ack & ~i_flush;
    assign stall_me = d_req & ~d_ack;

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        cnt_n       = cnt;
        cancel_n    = cancel;
        mem_en_n    = 1'b0;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        i_ack_n     = 1'b0;
        d_ack_n     = 1'b0;
        i_rdata_n   = i_rdata;
        d_rdata_n   = d_rdata;

        case (state)
            IDLE: begin
                if (d_req) begin
                    owner_n     = OWN_D;
                    mem_en_n    = 1'b1;
                    mem_we_n    = d_we;
                    mem_addr_n  = d_addr;
                    mem_wdata_n = d_wdata;
                    state_n     = ISSUE;
                end else if (i_req && !i_flush) begin
                    owner_n    = OWN_I;
                    mem_en_n   = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = i_addr;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = CW'(MEM_LAT);
                state_n = WAIT;
                if (flush_hit) cancel_n = 1'b1;
            end
            WAIT: begin
                if (flush_hit) cancel_n = 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                    if (owner == OWN_D) begin
                        d_ack_n = 1'b1;
                        if (!mem_we) d_rdata_n = mem_rdata;
                    end else if ((owner == OWN_I) && !cancel && !i_flush) begin
                        i_ack_n   = 1'b1;
                        i_rdata_n = mem_rdata;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DONE: begin
                // No re-arbitration here: the acked requester still shows req.
                state_n  = IDLE;
                owner_n  = OWN_NONE;
                cancel_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset_0) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            cnt       <= '0;
            cancel    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            cnt       <= cnt_n;
            cancel    <= cancel_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            i_ack     <= i_ack_n;
            d_ack     <= d_ack_n;
            i_rdata   <= i_rdata_n;
            d_rdata   <= d_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 15) share stimulus;
// instance 0 carries the functional scenarios, all three the back-to-back spacing.
module tb_mem_port_arbiter;
    localparam int unsigned NI = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    logic          clock   = 1'b0;
    logic          reset_0 = 1'b1;
    logic          i_req   = 1'b0;
    logic          i_flush = 1'b0;
    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [31:0]   i_addr  = '0;
    logic [31:0]   d_addr  = '0;
    logic [31:0]   d_wdata = '0;
    logic [NI-1:0] i_ack, d_ack, stall_if, stall_me, mem_en, mem_we;
    logic [31:0]   i_rdata [NI];
    logic [31:0]   d_rdata [NI];
    logic [31:0]   mem_addr [NI];
    logic [31:0]   mem_wdata [NI];
    logic [31:0]   mem_rdata [NI];

    logic [31:0] mem_model [logic [31:0]];
    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t iq[$];
    exp_t dq[$];
    int   bq[NI][$];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (mem_en[0] && mem_we[0]) mem_model[mem_addr[0]] = mem_wdata[0];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L = lat_of(g);
        logic [15:0] pv = '0;
        logic [31:0] pd [16];
        // Read data is only valid in the exact MEM_LAT cycle; garbage otherwise.
        always @(posedge clock) begin
            pv    <= {pv[14:0], mem_en[g] & ~mem_we[g]};
            pd[0] <= mem_read(mem_addr[g]);
            for (int k = 1; k < 16; k++) pd[k] <= pd[k-1];
        end
        assign mem_rdata[g] = pv[L-1] ? pd[L-1] : 32'hBAD0_BAD0;

        mem_port_arbiter #(.MEM_LAT(L), .AW(32), .DW(32)) dut (
            .clock    (clock),
            .reset_0  (reset_0),
            .i_req    (i_req),
            .i_addr   (i_addr),
            .i_flush  (i_flush),
            .i_ack    (i_ack[g]),
            .i_rdata  (i_rdata[g]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_ack    (d_ack[g]),
            .d_rdata  (d_rdata[g]),
            .stall_if (stall_if[g]),
            .stall_me (stall_me[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );
    end

    task automatic test_reset();
        reset_0 = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        n_cmp++;
        if ({i_ack[0], d_ack[0], mem_en[0], mem_we[0]} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b required 0000", {i_ack[0], d_ack[0], mem_en[0], mem_we[0]});
        end
        n_cmp++;
        if (i_rdata[0] !== 32'h0 || d_rdata[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: i=%h d=%h required 0", i_rdata[0], d_rdata[0]);
        end
        n_cmp++;
        if (mem_addr[0] !== 32'h0 || mem_wdata[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h required 0", mem_addr[0], mem_wdata[0]);
        end
        @(negedge clock);
        reset_0 = 1'b0;
        @(negedge clock);
        #2;
        n_cmp++;
        if (mem_en[0] !== 1'b0 || stall_if[0] !== 1'b0 || stall_me[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: en=%b sif=%b sme=%b required 0", mem_en[0], stall_if[0], stall_me[0]);
        end
    endtask

    task automatic test_if_fetch();
        int t0;
        bit done;
        exp_t e;
        done = 0;
        iq.delete();
        @(negedge clock);
        t0 = cyc;
        i_req = 1'b1;
        i_addr = 32'h0000_0040;
        iq.push_back('{t0 + 4, 32'h2008_0005});
        for (int k = 0; k < 20 && !done; k++) begin
            if (k > 0) @(negedge clock);
            #2;
            n_cmp++;
            if (mem_en[0] !== (k == 1)) begin
                n_bad++;
                $display("FAIL if_mem_en k=%0d: got %b required %b", k, mem_en[0], (k == 1));
            end
            if (i_ack[0]) begin
                n_cmp++;
                if (iq.size() == 0) begin
                    n_bad++;
                    $display("FAIL if_ack_extra cycle %0d", cyc);
                end else begin
                    e = iq.pop_front();
                    if (cyc !== e.cyc || i_rdata[0] !== e.data) begin
                        n_bad++;
                        $display("FAIL if_ack: cycle %0d data %h required cycle %0d data %h", cyc, i_rdata[0], e.cyc, e.data);
                    end
                end
                i_req = 1'b0;
                done = 1;
            end else begin
                n_cmp++;
                if (stall_if[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL if_stall k=%0d: got %b required 1", k, stall_if[0]);
                end
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL if_timeout: no i_ack, required at cycle %0d", t0 + 4);
        end
    endtask

    task automatic test_priority();
        int t0;
        bit i_done, d_done, exp_en;
        exp_t e;
        i_done = 0; d_done = 0;
        iq.delete(); dq.delete();
        @(negedge clock);
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h0000_0044;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        dq.push_back('{t0 + 4, 32'hDEAD_BEEF});
        iq.push_back('{t0 + 9, 32'h0000_0013});
        for (int k = 0; k < 24 && !(i_done && d_done); k++) begin
            if (k > 0) @(negedge clock);
            #2;
            exp_en = (k == 1) || (k == 6);
            n_cmp++;
            if (mem_en[0] !== exp_en || (exp_en && mem_addr[0] !== ((k == 1) ? 32'h100 : 32'h44))) begin
                n_bad++;
                $display("FAIL prio_mem_en k=%0d: en=%b addr=%h required en=%b", k, mem_en[0], mem_addr[0], exp_en);
            end
            if (d_ack[0]) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_bad++;
                    $display("FAIL prio_d_ack_extra cycle %0d", cyc);
                end else begin
                    e = dq.pop_front();
                    if (cyc !== e.cyc || d_rdata[0] !== e.data) begin
                        n_bad++;
                        $display("FAIL prio_d_ack: cycle %0d data %h required cycle %0d data %h", cyc, d_rdata[0], e.cyc, e.data);
                    end
                end
                d_req = 1'b0;
                d_done = 1;
            end
            if (i_ack[0]) begin
                n_cmp++;
                if (iq.size() == 0) begin
                    n_bad++;
                    $display("FAIL prio_i_ack_extra cycle %0d", cyc);
                end else begin
                    e = iq.pop_front();
                    if (cyc !== e.cyc || i_rdata[0] !== e.data) begin
                        n_bad++;
                        $display("FAIL prio_i_ack: cycle %0d data %h required cycle %0d data %h", cyc, i_rdata[0], e.cyc, e.data);
                    end
                end
                i_req = 1'b0;
                i_done = 1;
            end else if (!i_done) begin
                n_cmp++;
                if (stall_if[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL prio_stall_if k=%0d: got %b required 1", k, stall_if[0]);
                end
            end
        end
        if (!(i_done && d_done)) begin
            n_cmp++; n_bad++;
            $display("FAIL prio_timeout: i_done=%0d d_done=%0d required both 1", i_done, d_done);
        end
    endtask

    task automatic test_store();
        int t0;
        bit done;
        exp_t e;
        dq.delete();
        for (int ph = 0; ph < 2; ph++) begin
            done = 0;
            @(negedge clock);
            t0 = cyc;
            d_req = 1'b1; d_we = (ph == 0);
            d_addr = 32'h0000_0200; d_wdata = 32'h1234_5678;
            dq.push_back('{t0 + 4, (ph == 0) ? 32'hDEAD_BEEF : 32'h1234_5678});
            for (int k = 0; k < 12 && !done; k++) begin
                if (k > 0) @(negedge clock);
                #2;
                n_cmp++;
                if (k == 1) begin
                    if (mem_en[0] !== 1'b1 || mem_we[0] !== (ph == 0) || mem_addr[0] !== 32'h200 ||
                        (ph == 0 && mem_wdata[0] !== 32'h1234_5678)) begin
                        n_bad++;
                        $display("FAIL store_bus ph=%0d: en=%b we=%b addr=%h wdata=%h", ph, mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
                    end
                end else if (mem_en[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL store_mem_en ph=%0d k=%0d: got 1 required 0", ph, k);
                end
                if (d_ack[0]) begin
                    n_cmp++;
                    if (dq.size() == 0) begin
                        n_bad++;
                        $display("FAIL store_ack_extra cycle %0d", cyc);
                    end else begin
                        e = dq.pop_front();
                        if (cyc !== e.cyc || d_rdata[0] !== e.data) begin
                            n_bad++;
                            $display("FAIL store_ack ph=%0d: cycle %0d d_rdata %h required cycle %0d d_rdata %h", ph, cyc, d_rdata[0], e.cyc, e.data);
                        end
                    end
                    d_req = 1'b0;
                    done = 1;
                end
            end
            if (!done) begin
                n_cmp++; n_bad++;
                $display("FAIL store_timeout ph=%0d: no d_ack", ph);
            end
        end
        d_we = 1'b0;
    endtask

    task automatic test_flush();
        int t0;
        bit done;
        exp_t e;
        done = 0;
        iq.delete();
        t0 = 0;
        for (int k = 0; k < 16 && !done; k++) begin
            @(negedge clock);
            case (k)
                0: begin t0 = cyc; i_req = 1'b1; i_flush = 1'b1; i_addr = 32'h48; end
                1: i_flush = 1'b0;
                3: begin i_flush = 1'b1; i_req = 1'b0; end
                4: i_flush = 1'b0;
                6: begin i_req = 1'b1; i_addr = 32'h40; iq.push_back('{t0 + 10, 32'h2008_0005}); end
                default: ;
            endcase
            #2;
            n_cmp++;
            if (mem_en[0] !== ((k == 2) || (k == 7))) begin
                n_bad++;
                $display("FAIL flush_mem_en k=%0d: got %b required %b", k, mem_en[0], (k == 2) || (k == 7));
            end
            if (i_ack[0]) begin
                n_cmp++;
                if (iq.size() == 0) begin
                    n_bad++;
                    $display("FAIL flush_ack_after_cancel k=%0d: got i_ack 1 required 0", k);
                end else begin
                    e = iq.pop_front();
                    if (cyc !== e.cyc || i_rdata[0] !== e.data) begin
                        n_bad++;
                        $display("FAIL flush_refetch: cycle %0d data %h required cycle %0d data %h", cyc, i_rdata[0], e.cyc, e.data);
                    end
                end
                i_req = 1'b0;
                done = 1;
            end else begin
                n_cmp++;
                if (i_rdata[0] !== 32'h0000_0013 ||
                    stall_if[0] !== ((k == 1) || (k == 2) || (k >= 6))) begin
                    n_bad++;
                    $display("FAIL flush_hold k=%0d: i_rdata %h stall_if %b required 00000013 / %b", k, i_rdata[0], stall_if[0], (k == 1) || (k == 2) || (k >= 6));
                end
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL flush_timeout: no i_ack for refetch, required at cycle %0d", t0 + 10);
        end
    endtask

    task automatic test_reset_wait();
        int t0;
        bit done;
        exp_t e;
        done = 0;
        dq.delete();
        t0 = 0;
        for (int k = 0; k < 14 && !done; k++) begin
            @(negedge clock);
            if (k == 0) begin
                t0 = cyc;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
                dq.push_back('{t0 + 7, 32'hDEAD_BEEF});
            end
            if (k == 2) reset_0 = 1'b1;
            if (k == 3) reset_0 = 1'b0;
            #2;
            if (k == 3) begin
                n_cmp++;
                if ({i_ack[0], d_ack[0], mem_en[0], mem_we[0]} !== 4'b0 || i_rdata[0] !== 32'h0 ||
                    d_rdata[0] !== 32'h0 || mem_addr[0] !== 32'h0 || mem_wdata[0] !== 32'h0) begin
                    n_bad++;
                    $display("FAIL rstw_clear: acks/en/we %b i_rdata %h d_rdata %h addr %h wdata %h required all 0",
                             {i_ack[0], d_ack[0], mem_en[0], mem_we[0]}, i_rdata[0], d_rdata[0], mem_addr[0], mem_wdata[0]);
                end
            end
            n_cmp++;
            if (mem_en[0] !== ((k == 1) || (k == 4))) begin
                n_bad++;
                $display("FAIL rstw_mem_en k=%0d: got %b required %b", k, mem_en[0], (k == 1) || (k == 4));
            end
            if (d_ack[0]) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rstw_ack_extra cycle %0d", cyc);
                end else begin
                    e = dq.pop_front();
                    if (cyc !== e.cyc || d_rdata[0] !== e.data) begin
                        n_bad++;
                        $display("FAIL rstw_ack: cycle %0d data %h required cycle %0d data %h", cyc, d_rdata[0], e.cyc, e.data);
                    end
                end
                d_req = 1'b0;
                done = 1;
            end else begin
                n_cmp++;
                if (stall_me[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rstw_stall_me k=%0d: got %b required 1", k, stall_me[0]);
                end
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL rstw_timeout: no d_ack, required at cycle %0d", t0 + 7);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int e;
        @(negedge clock);
        reset_0 = 1'b1; i_req = 1'b0; i_flush = 1'b0; d_req = 1'b0;
        @(negedge clock);
        reset_0 = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        t0 = cyc;
        for (int g = 0; g < NI; g++) begin
            bq[g].delete();
            for (int c = t0 + 2 + lat_of(g); c < t0 + 70; c += lat_of(g) + 3) bq[g].push_back(c);
        end
        for (int k = 0; k < 70; k++) begin
            if (k > 0) @(negedge clock);
            #2;
            for (int g = 0; g < NI; g++) begin
                if (d_ack[g]) begin
                    n_cmp++;
                    if (bq[g].size() == 0) begin
                        n_bad++;
                        $display("FAIL b2b_extra lat=%0d: d_ack at cycle %0d not expected", lat_of(g), cyc);
                    end else begin
                        e = bq[g].pop_front();
                        if (cyc !== e || d_rdata[g] !== 32'hDEAD_BEEF) begin
                            n_bad++;
                            $display("FAIL b2b_ack lat=%0d: cycle %0d data %h required cycle %0d data deadbeef", lat_of(g), cyc, d_rdata[g], e);
                        end
                    end
                end
            end
        end
        for (int g = 0; g < NI; g++) begin
            n_cmp++;
            if (bq[g].size() != 0) begin
                n_bad++;
                $display("FAIL b2b_missing lat=%0d: %0d acks not seen, next required at cycle %0d", lat_of(g), bq[g].size(), bq[g][0]);
            end
        end
        d_req = 1'b0;
    endtask

    initial begin
        mem_model[32'h0000_0040] = 32'h2008_0005;
        mem_model[32'h0000_0044] = 32'h0000_0013;
        mem_model[32'h0000_0100] = 32'hDEAD_BEEF;
        test_reset();
        test_if_fetch();
        test_priority();
        test_store();
        test_flush();
        test_reset_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
